// File: rtl/seq_multiplier_sgn_if.sv
// Start/ready/done multiply bus: operands and mode in, product and status out.
interface seq_multiplier_sgn_if #(
  parameter int NB = 8
);
  logic            start;
  logic            sgn;
  logic [NB-1:0]   A;
  logic [NB-1:0]   B;
  logic [2*NB-1:0] Product;
  logic            ready;
  logic            done;

  modport master (output start, sgn, A, B, input Product, ready, done);
  modport slave  (input start, sgn, A, B, output Product, ready, done);
endinterface

// File: rtl/seq_multiplier_sgn.sv
// Iterative signed/unsigned shift-add multiplier; NB cycles accept-to-done, NB+1 back-to-back.
// Only accepts start while ready=1; start during RUN is ignored, result held until next accept.
module seq_multiplier_sgn #(
  parameter int NB = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_multiplier_sgn_if.slave mul_if
);
  localparam int CNT_W = $clog2(NB) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NB-1:0]   mcand_q;
  logic            mode_q;
  logic            ready_q;
  logic            done_q;
  logic [2*NB-1:0] prod_q;

  logic [NB:0]     acc_ext;
  logic [NB:0]     addend;
  logic [NB:0]     sum_d;
  logic            last_step;

  // Multiplier MSB carries weight -2^(NB-1) in signed mode, so the last step subtracts.
  always_comb begin
    acc_ext   = mode_q ? {prod_q[2*NB-1], prod_q[2*NB-1:NB]} : {1'b0, prod_q[2*NB-1:NB]};
    addend    = mode_q ? {mcand_q[NB-1], mcand_q} : {1'b0, mcand_q};
    last_step = (cnt_q == CNT_W'(NB - 1));
    sum_d     = acc_ext;
    if (prod_q[0]) begin
      sum_d = (mode_q && last_step) ? (acc_ext - addend) : (acc_ext + addend);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (mul_if.start) begin
            mcand_q <= mul_if.A;
            mode_q  <= mul_if.sgn;
            cnt_q   <= '0;
            prod_q  <= {{NB{1'b0}}, mul_if.B};
            state_q <= RUN;
            ready_q <= 1'b0;
          end
        end
        RUN: begin
          prod_q <= {sum_d, prod_q[NB-1:1]};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_if.Product = prod_q;
  assign mul_if.ready   = ready_q;
  assign mul_if.done    = done_q;
endmodule
